// File: rtl/eprisc_uart.sv
// eprisc_uart: memory-mapped 8N1 UART with RX/TX FIFOs and a level interrupt.
// Latency: DATA write to TX start bit is 2 clocks; RX byte visible 1 clock after the stop sample.
// Backpressure: none on the bus; a write to a full TX FIFO is dropped, an RX byte into a full FIFO sets overrun.
//
// Ports:
//   iClock, iReset      bus clock, synchronous active-high reset
//   iAddress[1:0]       register select: 0 DATA, 1 STATUS, 2 DIVISOR, 3 CONTROL
//   bData               bidirectional bus data, driven only during a read access
//   iWrite, iEnable     access direction and window select
//   oInterrupt          registered level interrupt
//   iReceive            asynchronous serial input (idle high)
//   oTransmit           registered serial output (idle high)
module eprisc_uart #(
   parameter int          FIFO_DEPTH      = 16,
   parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic [31:0] iAddress,
   inout  wire  [31:0] bData,
   input  logic        iWrite,
   input  logic        iEnable,
   output logic        oInterrupt,
   input  logic        iReceive,
   output logic        oTransmit
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [31:0] bus_wdat;
   logic [1:0]  reg_sel;
   logic        unused_bits;

   assign bus_wdat    = bData;
   assign reg_sel     = iAddress[1:0];
   assign unused_bits = ^{iAddress[31:2], bus_wdat[31:16]};

   // ---------------- bus strobe qualification ----------------
   // An action fires only on the first cycle of an access; holding iEnable
   // with the same direction does not repeat a push, pop or clear.
   logic prev_en_q, prev_en_d, prev_wr_q, prev_wr_d;
   logic first_cyc, wr_fire, rd_fire;

   assign first_cyc = iEnable && !(prev_en_q && (prev_wr_q == iWrite));
   assign wr_fire   = first_cyc && iWrite;
   assign rd_fire   = first_cyc && !iWrite;

   // ---------------- registers ----------------
   logic [15:0] divisor_q, divisor_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic        ovr_q, ovr_d, fe_q, fe_d;
   logic        irq_q, irq_d;

   // ---------------- TX FIFO ----------------
   logic [7:0]    tx_mem_q [FIFO_DEPTH];
   logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic          tx_full, tx_empty, tx_push, tx_pop;
   logic [7:0]    tx_head;

   assign tx_full  = (tx_cnt_q == DEPTH_C);
   assign tx_empty = (tx_cnt_q == '0);
   assign tx_head  = tx_mem_q[tx_rd_ptr_q];
   assign tx_push  = wr_fire && (reg_sel == 2'd0) && !tx_full;

   // ---------------- RX FIFO ----------------
   logic [7:0]    rx_mem_q [FIFO_DEPTH];
   logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic          rx_full, rx_empty, rx_push, rx_pop;
   logic [7:0]    rx_head;

   assign rx_full  = (rx_cnt_q == DEPTH_C);
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_head  = rx_mem_q[rx_rd_ptr_q];
   assign rx_pop   = rd_fire && (reg_sel == 2'd0) && !rx_empty;

   // ---------------- TX FSM state ----------------
   state_t      tx_state_q, tx_state_d;
   logic [15:0] tx_bcnt_q, tx_bcnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_line_q, tx_line_d;
   logic        tx_tick, tx_idle;

   assign tx_tick = (tx_bcnt_q == '0);
   assign tx_idle = tx_empty && (tx_state_q == S_IDLE);

   // ---------------- RX FSM state ----------------
   logic        sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
   state_t      rx_state_q, rx_state_d;
   logic [15:0] rx_bcnt_q, rx_bcnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_tick, rx_stop_smp, set_ovr, set_fe;
   logic [16:0] div_p1;
   logic [15:0] half_bit, half_load;

   assign rx_tick   = (rx_bcnt_q == '0);
   assign div_p1    = {1'b0, divisor_q} + 17'd1;
   assign half_bit  = div_p1[16:1];
   // Counter counts down to 0 inclusive, so load one less than the wait.
   assign half_load = (half_bit == '0) ? 16'd0 : half_bit - 16'd1;

   // ---------------- TX next-state ----------------
   always_comb begin
      tx_state_d = tx_state_q;
      tx_bcnt_d  = tx_bcnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         S_IDLE: begin
            if (!tx_empty) begin
               tx_state_d = S_START;
               tx_bcnt_d  = divisor_q;
               tx_shift_d = tx_head;
               tx_pop     = 1'b1;
            end
         end
         S_START: begin
            if (tx_tick) begin
               tx_state_d = S_DATA;
               tx_bcnt_d  = divisor_q;
               tx_bit_d   = 3'd0;
            end else begin
               tx_bcnt_d = tx_bcnt_q - 16'd1;
            end
         end
         S_DATA: begin
            if (tx_tick) begin
               tx_bcnt_d  = divisor_q;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
               else                  tx_bit_d   = tx_bit_q + 3'd1;
            end else begin
               tx_bcnt_d = tx_bcnt_q - 16'd1;
            end
         end
         default: begin
            // STOP chains straight into the next START when more data waits.
            if (tx_tick) begin
               if (!tx_empty) begin
                  tx_state_d = S_START;
                  tx_bcnt_d  = divisor_q;
                  tx_shift_d = tx_head;
                  tx_pop     = 1'b1;
               end else begin
                  tx_state_d = S_IDLE;
               end
            end else begin
               tx_bcnt_d = tx_bcnt_q - 16'd1;
            end
         end
      endcase
   end

   // ---------------- TX output ----------------
   always_comb begin
      tx_line_d = 1'b1;
      case (tx_state_q)
         S_START: tx_line_d = 1'b0;
         S_DATA:  tx_line_d = tx_shift_q[0];
         default: tx_line_d = 1'b1;
      endcase
   end

   // ---------------- RX next-state ----------------
   always_comb begin
      rx_state_d = rx_state_q;
      rx_bcnt_d  = rx_bcnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      case (rx_state_q)
         S_IDLE: begin
            if (rx_prev_q && !sync2_q) begin
               rx_state_d = S_START;
               rx_bcnt_d  = half_load;
            end
         end
         S_START: begin
            if (rx_tick) begin
               if (sync2_q) begin
                  rx_state_d = S_IDLE;        // line back high: glitch
               end else begin
                  rx_state_d = S_DATA;
                  rx_bcnt_d  = divisor_q;
                  rx_bit_d   = 3'd0;
               end
            end else begin
               rx_bcnt_d = rx_bcnt_q - 16'd1;
            end
         end
         S_DATA: begin
            if (rx_tick) begin
               rx_shift_d = {sync2_q, rx_shift_q[7:1]};
               rx_bcnt_d  = divisor_q;
               if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_bcnt_d = rx_bcnt_q - 16'd1;
            end
         end
         default: begin
            if (rx_tick) rx_state_d = S_IDLE;
            else         rx_bcnt_d  = rx_bcnt_q - 16'd1;
         end
      endcase
   end

   // ---------------- RX output ----------------
   always_comb begin
      rx_stop_smp = (rx_state_q == S_STOP) && rx_tick;
      rx_push     = rx_stop_smp && sync2_q && !rx_full;
      set_ovr     = rx_stop_smp && sync2_q && rx_full;
      set_fe      = rx_stop_smp && !sync2_q;
   end

   // ---------------- FIFO pointers / counts, registers ----------------
   always_comb begin
      prev_en_d   = iEnable;
      prev_wr_d   = iWrite;
      sync1_d     = iReceive;
      sync2_d     = sync1_q;
      rx_prev_d   = sync2_q;

      tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + 1'b1 : tx_wr_ptr_q;
      tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + 1'b1 : tx_rd_ptr_q;
      tx_cnt_d    = tx_cnt_q;
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;

      rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + 1'b1 : rx_wr_ptr_q;
      rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + 1'b1 : rx_rd_ptr_q;
      rx_cnt_d    = rx_cnt_q;
      if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;

      divisor_d = divisor_q;
      ctrl_d    = ctrl_q;
      ovr_d     = ovr_q;
      fe_d      = fe_q;
      if (wr_fire) begin
         case (reg_sel)
            2'd1: begin
               if (bus_wdat[3]) ovr_d = 1'b0;
               if (bus_wdat[4]) fe_d  = 1'b0;
            end
            2'd2:    divisor_d = bus_wdat[15:0];
            2'd3:    ctrl_d    = bus_wdat[1:0];
            default: ;
         endcase
      end
      // A new error in the same cycle as a clear wins.
      if (set_ovr) ovr_d = 1'b1;
      if (set_fe)  fe_d  = 1'b1;

      irq_d = (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_idle);
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         prev_en_q   <= 1'b0;
         prev_wr_q   <= 1'b0;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
         tx_wr_ptr_q <= '0;
         tx_rd_ptr_q <= '0;
         tx_cnt_q    <= '0;
         rx_wr_ptr_q <= '0;
         rx_rd_ptr_q <= '0;
         rx_cnt_q    <= '0;
         divisor_q   <= DEFAULT_DIVISOR;
         ctrl_q      <= 2'b00;
         ovr_q       <= 1'b0;
         fe_q        <= 1'b0;
         irq_q       <= 1'b0;
         tx_state_q  <= S_IDLE;
         tx_bcnt_q   <= '0;
         tx_bit_q    <= '0;
         tx_shift_q  <= '0;
         tx_line_q   <= 1'b1;
         rx_state_q  <= S_IDLE;
         rx_bcnt_q   <= '0;
         rx_bit_q    <= '0;
         rx_shift_q  <= '0;
      end else begin
         prev_en_q   <= prev_en_d;
         prev_wr_q   <= prev_wr_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         rx_prev_q   <= rx_prev_d;
         tx_wr_ptr_q <= tx_wr_ptr_d;
         tx_rd_ptr_q <= tx_rd_ptr_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_wr_ptr_q <= rx_wr_ptr_d;
         rx_rd_ptr_q <= rx_rd_ptr_d;
         rx_cnt_q    <= rx_cnt_d;
         divisor_q   <= divisor_d;
         ctrl_q      <= ctrl_d;
         ovr_q       <= ovr_d;
         fe_q        <= fe_d;
         irq_q       <= irq_d;
         tx_state_q  <= tx_state_d;
         tx_bcnt_q   <= tx_bcnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         tx_line_q   <= tx_line_d;
         rx_state_q  <= rx_state_d;
         rx_bcnt_q   <= rx_bcnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
      end
   end

   // FIFO storage needs no reset; emptiness is defined by the pointers.
   always_ff @(posedge iClock) begin
      if (tx_push) tx_mem_q[tx_wr_ptr_q] <= bus_wdat[7:0];
      if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_shift_q;
   end

   // ---------------- read mux and outputs ----------------
   logic [31:0] rd_data;
   always_comb begin
      rd_data = 32'h0;
      case (reg_sel)
         2'd0:    rd_data = rx_empty ? 32'h0 : {24'h0, rx_head};
         2'd1:    rd_data = {27'h0, fe_q, ovr_q, tx_idle, !tx_full, !rx_empty};
         2'd2:    rd_data = {16'h0, divisor_q};
         default: rd_data = {30'h0, ctrl_q};
      endcase
   end

   assign bData      = (iEnable && !iWrite) ? rd_data : 32'hz;
   assign oTransmit  = tx_line_q;
   assign oInterrupt = irq_q;

endmodule

// File: tb/tb_eprisc_uart.sv
// Directed bench for eprisc_uart: register reset values, TX waveform, RX
// reception, overrun, framing error, glitch rejection, TX burst and reset.
module tb_eprisc_uart;

   logic        iClock   = 1'b0;
   logic        iReset   = 1'b1;
   logic [31:0] iAddress = 32'h0;
   logic        iWrite   = 1'b0;
   logic        iEnable  = 1'b0;
   logic        iReceive = 1'b1;
   wire  [31:0] bData;
   wire         oInterrupt;
   wire         oTransmit;

   logic        drv_en  = 1'b0;
   logic [31:0] drv_dat = 32'h0;
   assign bData = drv_en ? drv_dat : 32'hz;

   int n_checks = 0;
   int n_fail   = 0;

   eprisc_uart #(.FIFO_DEPTH(16), .DEFAULT_DIVISOR(16'd433)) dut (
      .iClock(iClock), .iReset(iReset), .iAddress(iAddress), .bData(bData),
      .iWrite(iWrite), .iEnable(iEnable), .oInterrupt(oInterrupt),
      .iReceive(iReceive), .oTransmit(oTransmit)
   );

   always #5 iClock = ~iClock;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge iClock);
      iAddress = {30'h0, a}; iWrite = 1'b1; iEnable = 1'b1;
      drv_en = 1'b1; drv_dat = d;
      @(negedge iClock);
      iEnable = 1'b0; iWrite = 1'b0; drv_en = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, input int hold, output logic [31:0] d);
      @(negedge iClock);
      iAddress = {30'h0, a}; iWrite = 1'b0; iEnable = 1'b1;
      #1 d = bData;
      repeat (hold) @(negedge iClock);
      iEnable = 1'b0;
   endtask

   // 4 clocks per bit (DIVISOR=3), start, 8 data LSB first, stop.
   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge iClock);
         iReceive = fr[i];
         repeat (3) @(negedge iClock);
      end
      @(negedge iClock);
      iReceive = 1'b1;
   endtask

   function automatic logic [7:0] burst_byte(input int i);
      return 8'(i * 37 + 1);
   endfunction

   task automatic test_reset;
      logic [31:0] d;
      iReset = 1'b1;
      repeat (3) @(negedge iClock);
      iReset = 1'b0;
      n_checks++;
      if (oTransmit !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", oTransmit); end
      n_checks++;
      if (oInterrupt !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", oInterrupt); end
      bus_read(2'd1, 1, d);
      n_checks++;
      if (d !== 32'h6) begin n_fail++; $display("FAIL reset_status: got %h expected %h", d, 32'h6); end
      bus_read(2'd2, 1, d);
      n_checks++;
      if (d !== 32'd433) begin n_fail++; $display("FAIL reset_divisor: got %0d expected 433", d); end
      bus_read(2'd3, 1, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_control: got %h expected 0", d); end
      bus_read(2'd0, 1, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_data_empty: got %h expected 0", d); end
   endtask

   task automatic test_tx_single;
      logic [31:0] d;
      logic [9:0]  fr;
      int          cnt, bad;
      bus_write(2'd2, 32'd3);
      bus_write(2'd3, 32'd2);
      @(negedge iClock);
      n_checks++;
      if (oInterrupt !== 1'b1) begin n_fail++; $display("FAIL tx_idle_irq: got %b expected 1", oInterrupt); end
      bus_write(2'd3, 32'd0);
      bus_write(2'd0, 32'h55);
      cnt = 0;
      while (oTransmit !== 1'b0 && cnt < 20) begin @(negedge iClock); cnt++; end
      n_checks++;
      if (cnt != 2) begin n_fail++; $display("FAIL tx_latency: got %0d clocks expected 2", cnt); end
      fr  = {1'b1, 8'h55, 1'b0};
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         if (oTransmit !== fr[k / 4]) bad++;
         @(negedge iClock);
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL tx_wave_55: got %0d bad clocks expected 0", bad); end
      n_checks++;
      if (oTransmit !== 1'b1) begin n_fail++; $display("FAIL tx_after_stop: got %b expected 1", oTransmit); end
      bus_read(2'd1, 1, d);
      n_checks++;
      if (d !== 32'h6) begin n_fail++; $display("FAIL tx_idle_status: got %h expected %h", d, 32'h6); end
   endtask

   task automatic test_rx;
      logic [31:0] d;
      bus_write(2'd3, 32'd1);
      send_rx(8'hA3, 1'b1);
      send_rx(8'h3C, 1'b1);
      repeat (3) @(negedge iClock);
      bus_read(2'd1, 1, d);
      n_checks++;
      if (d !== 32'h7) begin n_fail++; $display("FAIL rx_status: got %h expected %h", d, 32'h7); end
      n_checks++;
      if (oInterrupt !== 1'b1) begin n_fail++; $display("FAIL rx_irq: got %b expected 1", oInterrupt); end
      bus_read(2'd0, 3, d);          // held read must pop only once
      n_checks++;
      if (d !== 32'hA3) begin n_fail++; $display("FAIL rx_byte0: got %h expected %h", d, 32'hA3); end
      bus_read(2'd0, 1, d);
      n_checks++;
      if (d !== 32'h3C) begin n_fail++; $display("FAIL rx_byte1: got %h expected %h", d, 32'h3C); end
      bus_read(2'd1, 1, d);
      n_checks++;
      if (d !== 32'h6) begin n_fail++; $display("FAIL rx_status_empty: got %h expected %h", d, 32'h6); end
      @(negedge iClock);
      n_checks++;
      if (oInterrupt !== 1'b0) begin n_fail++; $display("FAIL rx_irq_clear: got %b expected 0", oInterrupt); end
      bus_read(2'd0, 1, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL rx_read_empty: got %h expected 0", d); end
      bus_write(2'd3, 32'd0);
   endtask

   task automatic test_overrun;
      logic [31:0] d;
      int          bad;
      for (int i = 0; i < 17; i++) send_rx(8'(8'h10 + i), 1'b1);
      repeat (3) @(negedge iClock);
      bus_read(2'd1, 1, d);
      n_checks++;
      if (d !== 32'hF) begin n_fail++; $display("FAIL ovr_status: got %h expected %h", d, 32'hF); end
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         bus_read(2'd0, 1, d);
         if (d !== {24'h0, 8'(8'h10 + i)}) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL ovr_fifo_order: got %0d bad bytes expected 0", bad); end
      bus_read(2'd1, 1, d);
      n_checks++;
      if (d !== 32'hE) begin n_fail++; $display("FAIL ovr_sticky: got %h expected %h", d, 32'hE); end
      bus_write(2'd1, 32'h8);
      bus_read(2'd1, 1, d);
      n_checks++;
      if (d !== 32'h6) begin n_fail++; $display("FAIL ovr_clear: got %h expected %h", d, 32'h6); end
   endtask

   task automatic test_framing_glitch;
      logic [31:0] d;
      send_rx(8'h5A, 1'b0);
      repeat (3) @(negedge iClock);
      bus_read(2'd1, 1, d);
      n_checks++;
      if (d !== 32'h16) begin n_fail++; $display("FAIL fe_status: got %h expected %h", d, 32'h16); end
      bus_write(2'd1, 32'h10);
      bus_read(2'd1, 1, d);
      n_checks++;
      if (d !== 32'h6) begin n_fail++; $display("FAIL fe_clear: got %h expected %h", d, 32'h6); end
      @(negedge iClock);
      iReceive = 1'b0;
      @(negedge iClock);
      iReceive = 1'b1;
      repeat (40) @(negedge iClock);
      bus_read(2'd1, 1, d);
      n_checks++;
      if (d !== 32'h6) begin n_fail++; $display("FAIL glitch_status: got %h expected %h", d, 32'h6); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] d;
      logic [9:0]  fr;
      int          cnt, bad, bad_idle;
      // 18 writes: one goes straight to the shifter, 16 fill the FIFO, the last is dropped.
      fork
         begin
            for (int i = 0; i < 18; i++) bus_write(2'd0, {24'h0, burst_byte(i)});
            bus_read(2'd1, 1, d);
            n_checks++;
            if (d !== 32'h0) begin n_fail++; $display("FAIL burst_full_status: got %h expected 0", d); end
         end
         begin
            cnt = 0;
            while (oTransmit !== 1'b0 && cnt < 40) begin @(negedge iClock); cnt++; end
            bad = (cnt >= 40) ? 1 : 0;
            for (int k = 0; k < 17 * 40; k++) begin
               fr = {1'b1, burst_byte(k / 40), 1'b0};
               if (oTransmit !== fr[(k % 40) / 4]) bad++;
               @(negedge iClock);
            end
            n_checks++;
            if (bad != 0) begin n_fail++; $display("FAIL burst_wave: got %0d bad clocks expected 0", bad); end
            bad_idle = 0;
            for (int k = 0; k < 60; k++) begin
               if (oTransmit !== 1'b1) bad_idle++;
               @(negedge iClock);
            end
            n_checks++;
            if (bad_idle != 0) begin n_fail++; $display("FAIL burst_drop_18th: got %0d low clocks expected 0", bad_idle); end
         end
      join
      bus_read(2'd1, 1, d);
      n_checks++;
      if (d !== 32'h6) begin n_fail++; $display("FAIL burst_done_status: got %h expected %h", d, 32'h6); end

      // Reset in the start bit of frame 3.
      fork
         begin
            bus_write(2'd0, 32'hF0);
            bus_write(2'd0, 32'h0F);
            bus_write(2'd0, 32'h00);
            bus_write(2'd0, 32'hAA);
         end
         begin
            cnt = 0;
            while (oTransmit !== 1'b0 && cnt < 40) begin @(negedge iClock); cnt++; end
            repeat (82) @(negedge iClock);
            n_checks++;
            if (oTransmit !== 1'b0 || cnt >= 40) begin n_fail++; $display("FAIL rst_pre_frame3: got %b expected 0", oTransmit); end
            iReset = 1'b1;
            @(negedge iClock);
            n_checks++;
            if (oTransmit !== 1'b1) begin n_fail++; $display("FAIL rst_tx_high: got %b expected 1", oTransmit); end
         end
      join
      @(negedge iClock);
      iReset = 1'b0;
      bad_idle = 0;
      for (int k = 0; k < 200; k++) begin
         if (oTransmit !== 1'b1) bad_idle++;
         @(negedge iClock);
      end
      n_checks++;
      if (bad_idle != 0) begin n_fail++; $display("FAIL rst_no_frames: got %0d low clocks expected 0", bad_idle); end
      bus_read(2'd1, 1, d);
      n_checks++;
      if (d !== 32'h6) begin n_fail++; $display("FAIL rst_status: got %h expected %h", d, 32'h6); end
      bus_read(2'd2, 1, d);
      n_checks++;
      if (d !== 32'd433) begin n_fail++; $display("FAIL rst_divisor: got %0d expected 433", d); end
   endtask

   initial begin
      test_reset();
      test_tx_single();
      test_rx();
      test_overrun();
      test_framing_glitch();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
